// File: rtl/arb_pkg.sv
// Shared constants for the 8-way round-robin arbiter: sizes, FSM state codes
// and the hold-counter width used by the optional ARB_TIMEOUT_EN feature.
package arb_pkg;

  localparam int NREQ   = 8;
  localparam int IDXW   = 3;
  localparam int HCNT_W = 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

endpackage

// File: rtl/rr_prio_enc8.sv
// Rotating 8-to-3 priority encoder: first set bit of vec scanning ptr, ptr+1, ... (mod 8).
// Purely combinational; any is high when vec has at least one bit set.
module rr_prio_enc8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] vec,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  logic [NREQ-1:0] rot;
  logic [IDXW-1:0] off;

  // Rotate so that bit ptr lands at position 0, then a fixed lowest-first encode.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = vec[IDXW'(i) + ptr];
    end
  end

  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDXW'(i);
      end
    end
  end

  assign idx = off + ptr;
  assign any = |vec;

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Registered 8-way round-robin arbiter with request-hold / release-by-drop handshake.
// Define ARB_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles (pulses timeout).
module rr_arb8_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld,
  output logic            timeout
);

  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAX_HOLD - 1);

  logic [0:0]      state;
  logic [IDXW-1:0] ptr;
  logic [NREQ-1:0] cand;
  logic [IDXW-1:0] win_idx;
  logic            win_any;
  logic            owner_hold;
  logic            revoke;
  logic            keep;

  // gnt is zero in IDLE, so masking the owner is correct in both states.
  assign cand       = req & ~gnt;
  assign owner_hold = (state == BUSY) && req[gnt_idx];
  assign keep       = owner_hold && !revoke;

  rr_prio_enc8 u_enc (
    .vec (cand),
    .ptr (ptr),
    .idx (win_idx),
    .any (win_any)
  );

`ifdef ARB_TIMEOUT_EN
  logic [HCNT_W-1:0] hold_cnt;

  assign revoke = owner_hold && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (keep) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  logic [HCNT_W-1:0] unused_hold_last;

  assign unused_hold_last = HOLD_LAST;
  assign revoke           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= revoke;
      if (keep) begin
        state <= BUSY;
      end else if (en && win_any) begin
        // New grant or back-to-back handover; ptr moves just past the winner.
        state   <= BUSY;
        ptr     <= win_idx + 1'b1;
        gnt     <= NREQ'(1) << win_idx;
        gnt_idx <= win_idx;
        gnt_vld <= 1'b1;
      end else begin
        state   <= IDLE;
        gnt     <= '0;
        gnt_idx <= '0;
        gnt_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Bench for rr_arb8_ctrl: vector table plus hold/timeout sequences, scoreboard-checked.
module tb_rr_arb8_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } vec_t;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];
  out_t sb[$];

  rr_arb8_ctrl #(.MAX_HOLD(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic [7:0] rq,
                     input logic [7:0] g, input logic [2:0] ix, input logic v);
    vec_t t;
    t.rst_n = r; t.en = e; t.req = rq;
    t.gnt = g; t.idx = ix; t.vld = v; t.to = 1'b0;
    tbl.push_back(t);
  endtask

  // Drive inputs, queue the expected post-edge outputs, then compare after the edge.
  task automatic step(input string name, input logic r, input logic e, input logic [7:0] rq,
                      input logic [7:0] g, input logic [2:0] ix, input logic v, input logic to);
    out_t exp_o;
    out_t got;
    rst_n = r; en = e; req = rq;
    exp_o.gnt = g; exp_o.idx = ix; exp_o.vld = v; exp_o.to = to;
    sb.push_back(exp_o);
    @(posedge clk);
    #1;
    got = '{gnt: gnt, idx: gnt_idx, vld: gnt_vld, to: timeout};
    exp_o = sb.pop_front();
    checks++;
    if (got !== exp_o) begin
      errors++;
      $display("FAIL %s: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
               name, got.gnt, got.idx, got.vld, got.to, exp_o.gnt, exp_o.idx, exp_o.vld, exp_o.to);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req = 8'h00;

    // Reset, then idle
    add(0, 1, 8'h00, 8'h00, 0, 0);
    add(0, 1, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 1, 8'h00, 8'h00, 0, 0);
    // Wrap priority: 0 wins, then 7 at the release edge, ptr wraps to 0
    add(1, 1, 8'h81, 8'h01, 0, 1);
    add(1, 1, 8'h80, 8'h80, 7, 1);
    add(1, 1, 8'h80, 8'h80, 7, 1);
    add(1, 1, 8'h00, 8'h00, 0, 0);
    // Fairness: all request, each owner drops for one cycle -> 0..7,0
    add(1, 1, 8'hFF, 8'h01, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      logic [7:0] rq;
      logic [7:0] g;
      rq = ~(8'h01 << (k - 1));
      g  = 8'h01 << (k % 8);
      add(1, 1, rq, g, 3'(k % 8), 1);
    end
    add(1, 1, 8'h00, 8'h00, 0, 0);
    // Enable gating (ptr=1 here)
    add(1, 0, 8'h10, 8'h00, 0, 0);
    add(1, 0, 8'h10, 8'h00, 0, 0);
    add(1, 1, 8'h10, 8'h10, 4, 1);
    add(1, 0, 8'h10, 8'h10, 4, 1);
    add(1, 0, 8'h10, 8'h10, 4, 1);
    add(1, 0, 8'h00, 8'h00, 0, 0);
    add(1, 0, 8'h10, 8'h00, 0, 0);
    add(1, 1, 8'h00, 8'h00, 0, 0);
    // Reset mid-grant, then ptr restarts at 0
    add(1, 1, 8'h08, 8'h08, 3, 1);
    add(1, 1, 8'h08, 8'h08, 3, 1);
    add(0, 1, 8'h08, 8'h00, 0, 0);
    add(1, 1, 8'h0C, 8'h04, 2, 1);
    add(1, 1, 8'h00, 8'h00, 0, 0);
    // Release with en low and another requester pending -> idle (ptr=3)
    add(1, 1, 8'h03, 8'h01, 0, 1);
    add(1, 0, 8'h02, 8'h00, 0, 0);
    add(1, 1, 8'h02, 8'h02, 1, 1);
    add(1, 1, 8'h00, 8'h00, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].en, tbl[i].req,
           tbl[i].gnt, tbl[i].idx, tbl[i].vld, tbl[i].to);
    end

    // Long hold: restart from reset so ptr=0
    step("hold_rst", 0, 1, 8'h00, 8'h00, 0, 0, 0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 16; c++) step($sformatf("hold%0d", c), 1, 1, 8'h08, 8'h08, 3, 1, 0);
    step("revoke", 1, 1, 8'h08, 8'h00, 0, 0, 1);
    step("regrant", 1, 1, 8'h08, 8'h08, 3, 1, 0);
    step("regrant2", 1, 1, 8'h08, 8'h08, 3, 1, 0);
    step("rel", 1, 1, 8'h00, 8'h00, 0, 0, 0);
    step("ho_rst", 0, 1, 8'h00, 8'h00, 0, 0, 0);
    for (int c = 0; c < 16; c++) step($sformatf("ho_hold%0d", c), 1, 1, 8'h18, 8'h08, 3, 1, 0);
    step("ho_revoke", 1, 1, 8'h18, 8'h10, 4, 1, 1);
    step("ho_after", 1, 1, 8'h18, 8'h10, 4, 1, 0);
    step("ho_rel", 1, 1, 8'h00, 8'h00, 0, 0, 0);
`else
    for (int c = 0; c < 20; c++) step($sformatf("hold%0d", c), 1, 1, 8'h08, 8'h08, 3, 1, 0);
    step("hold_ho", 1, 1, 8'h10, 8'h10, 4, 1, 0);
    step("rel", 1, 1, 8'h00, 8'h00, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arb8_ctrl.md
Name: rr_arb8_ctrl

Overview:
- Registered round-robin arbiter that shares one resource among 8 requesters.
- Built around a rotating 8-to-3 priority encoder; produces a one-hot grant and its 3-bit encoded index.
- Sits in front of any shared datapath unit (bus, ALU port, memory port) and sequences ownership with a request-hold / release-by-drop handshake.

Parameters:
- NREQ, 8, number of requesters (fixed at 8 in this revision; other values unsupported).
- IDXW, 3, width of the encoded grant index (log2 of NREQ).
- MAX_HOLD, 16, maximum consecutive grant cycles when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the clk rising edge.
- en  in  1  arbitration enable; 0 blocks new grants but does not revoke a held grant.
- req  in  8  request vector; bit i high = requester i wants or holds the resource.
- gnt  out  8  one-hot grant; all zero when idle.
- gnt_idx  out  3  encoded index of the granted requester; 0 when idle.
- gnt_vld  out  1  high while any grant is held.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs: gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
  - Internal: ptr=0, state=IDLE, hold counter=0.
  - Reset overrides everything, including mid-grant.
- Winner selection (combinational): the first set bit of the candidate vector, scanning ptr, ptr+1, …, ptr+7 (mod 8). The candidate vector is req, with the current owner's bit masked where stated below.
- States: IDLE, BUSY.
- IDLE:
  - If en=1 and req≠0 at the edge: register the winner into gnt/gnt_idx, set gnt_vld=1, set ptr=winner+1 (mod 8, 3-bit wrap, 7→0), go to BUSY.
  - Latency is one cycle from request sampled to grant visible.
  - Otherwise stay in IDLE.
- BUSY, owner still requesting (req[gnt_idx]=1): hold the grant unchanged; do not move ptr.
- BUSY, owner releases (req[gnt_idx]=0 at the edge):
  - If en=1 and (req with the owner's bit masked) ≠ 0: grant the new winner at that same edge. This is a back-to-back handover with no idle cycle; update ptr.
  - Otherwise clear gnt/gnt_vld/gnt_idx and go to IDLE.
- en falling during BUSY: grant is held until release, then go to IDLE.
- Requests arriving while BUSY: wait; they are never lost, provided they are held.
- Simultaneous requests: resolved only by rotating priority.
  - Fairness: any continuously asserted request is granted within 7 handovers.
- Invariants:
  - gnt is always zero or exactly one-hot.
  - gnt_idx always equals the encoded gnt.
  - gnt_vld equals OR-reduction of gnt.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter resets to 0 on every new grant and increments each BUSY cycle.
  - When the owner is still requesting and the counter reaches MAX_HOLD-1: revoke at that edge and pulse timeout=1 for one cycle.
  - ptr is already past the owner, so the next winner is selected with the owner's bit masked, exactly as a release.
  - The revoked requester may win again later in normal rotation.
- Undefined: no counter is built, timeout is tied to 0, and a grant is held indefinitely.

Decomposition:
- Package arb_pkg holds:
  - NREQ and IDXW constants.
  - State enumeration {IDLE, BUSY}.
  - Hold-counter width constant.
- Sub-module rr_prio_enc8 (combinational): inputs 8-bit vector and 3-bit ptr; outputs 3-bit index and any-valid. Implemented as rotate, fixed-priority 8-to-3 encode, add ptr.
- The controller instantiates rr_prio_enc8 once and owns all registers.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then req=0, en=1 → gnt=0, gnt_idx=0, gnt_vld=0 for 10 cycles.
- Wrap priority:
  - After reset (ptr=0), req=8'b1000_0001 → next cycle gnt=8'h01, idx=0.
  - Drop req[0] → same edge gnt=8'h80, idx=7, ptr wraps to 0.
- Round-robin fairness: req=8'hFF and each owner drops its bit for exactly one cycle after being granted → grant order 0,1,…,7,0 with no idle cycles.
- Enable gating:
  - en=0, req=8'h10 → no grant.
  - Set en=1 → gnt=8'h10 one cycle later.
  - Clear en while BUSY → grant is held until req[4] drops, then idle.
- Reset mid-grant: while gnt=8'h08 is held, assert rst_n=0 for 1 cycle → next edge gnt=0, gnt_vld=0; the next request 8'h0C is granted to idx 2 (ptr=0).
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=16):
  - req=8'h08 held 20 cycles → gnt=8'h08 for exactly 16 cycles, then timeout=1 for one cycle and gnt=0.
  - With req=8'h18 instead → handover to 8'h10 at the revoke edge.
